// File: rtl/xorshift_pkg.sv
// Shared constants and FSM type for the 32-bit xorshift (13/17/5) generator and its inverse.
package xorshift_pkg;

  localparam int unsigned XS_WIDTH = 32;
  localparam int unsigned XS_A     = 13;
  localparam int unsigned XS_B     = 17;
  localparam int unsigned XS_C     = 5;

  typedef enum logic [2:0] {
    StIdle,
    StUndo5,
    StUndo17,
    StUndo13,
    StDone
  } xs_state_e;

endpackage

// File: rtl/xorshift_rewind_if.sv
// Control/status bundle between a rewind client (master) and xorshift_rewind (slave).
interface xorshift_rewind_if #(
  parameter int unsigned COUNT_W = 16
);
  import xorshift_pkg::*;

  logic                load;
  logic [XS_WIDTH-1:0] load_state;
  logic                start;
  logic [COUNT_W-1:0]  steps;
  logic [XS_WIDTH-1:0] state_out;
  logic                busy;
  logic                done;

  modport master (
    output load, load_state, start, steps,
    input  state_out, busy, done
  );

  modport slave (
    input  load, load_state, start, steps,
    output state_out, busy, done
  );

endinterface

// File: rtl/xorshift_inv_stage.sv
// Combinational inverse of y ^ (y shift K): xor of y shifted by every multiple of K below 32.
module xorshift_inv_stage
  import xorshift_pkg::*;
#(
  parameter int unsigned K    = 5,
  parameter bit          Left = 1'b1
) (
  input  logic [XS_WIDTH-1:0] y,
  output logic [XS_WIDTH-1:0] x
);

  always_comb begin
    x = y;
    for (int unsigned i = 1; i * K < XS_WIDTH; i++) begin
      x = x ^ (Left ? (y << (i * K)) : (y >> (i * K)));
    end
  end

endmodule

// File: rtl/xorshift_rewind.sv
// Steps the xorshift sequence backwards N times, one inverse shift-xor stage per clock.
module xorshift_rewind
  import xorshift_pkg::*;
#(
  parameter logic [XS_WIDTH-1:0] SEED    = 32'hdeadbeef,
  parameter int unsigned         COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  xorshift_rewind_if.slave   bus
);

  xs_state_e           fsm_q;
  logic [XS_WIDTH-1:0] state_q;
  logic [COUNT_W-1:0]  remaining_q;
  logic                busy_q;
  logic                done_q;

  logic [XS_WIDTH-1:0] undo5, undo17, undo13, stage_x;

  // Forward order is 13, 17, 5, so the inverse undoes 5 first.
  xorshift_inv_stage #(.K(XS_C), .Left(1'b1)) u_undo5 (
    .y (state_q),
    .x (undo5)
  );

  xorshift_inv_stage #(.K(XS_B), .Left(1'b0)) u_undo17 (
    .y (state_q),
    .x (undo17)
  );

  xorshift_inv_stage #(.K(XS_A), .Left(1'b1)) u_undo13 (
    .y (state_q),
    .x (undo13)
  );

  always_comb begin
    stage_x = state_q;
    unique case (fsm_q)
      StUndo5:  stage_x = undo5;
      StUndo17: stage_x = undo17;
      StUndo13: stage_x = undo13;
      default:  stage_x = state_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q       <= StIdle;
      state_q     <= SEED;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (bus.load) begin
            state_q <= bus.load_state;
          end else if (bus.start) begin
            if (bus.steps != '0) begin
              remaining_q <= bus.steps;
              fsm_q       <= StUndo5;
              busy_q      <= 1'b1;
            end else begin
              fsm_q  <= StDone;
              done_q <= 1'b1;
            end
          end
        end
        StUndo5: begin
          state_q <= stage_x;
          fsm_q   <= StUndo17;
        end
        StUndo17: begin
          state_q <= stage_x;
          fsm_q   <= StUndo13;
        end
        StUndo13: begin
          state_q <= stage_x;
          if (remaining_q == COUNT_W'(1)) begin
            fsm_q  <= StDone;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            remaining_q <= remaining_q - COUNT_W'(1);
            fsm_q       <= StUndo5;
          end
        end
        StDone: begin
          fsm_q  <= StIdle;
          done_q <= 1'b0;
        end
        default: begin
          fsm_q  <= StIdle;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state_out = state_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_xorshift_rewind.sv
// Scoreboard bench for xorshift_rewind: expected states queued at start, checked at done.
module tb_xorshift_rewind;

  logic clock = 1'b0;
  logic reset = 1'b1;

  xorshift_rewind_if #(.COUNT_W(16)) bus ();

  xorshift_rewind #(.SEED(32'hdeadbeef), .COUNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [31:0] s);
    logic [31:0] a, b;
    a = s ^ (s << 13);
    b = a ^ (a >> 17);
    return b ^ (b << 5);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [31:0] v);
    bus.load       = 1'b1;
    bus.load_state = v;
    tick();
    bus.load = 1'b0;
    check_eq("load_value", bus.state_out, v);
  endtask

  // inject: poke load/start while busy and again in the DONE cycle; both must be ignored.
  task automatic run_rewind(input int n, input logic [31:0] exp, input bit inject);
    int cyc = 0;
    int busy_cnt = 0;
    bit got = 0;
    logic [31:0] want;
    sb_q.push_back(exp);
    bus.start = 1'b1;
    bus.steps = 16'(n);
    tick();
    bus.start = 1'b0;
    while (!got && cyc <= 3 * n + 8) begin
      if (bus.done) begin
        got = 1;
      end else begin
        if (bus.busy) busy_cnt++;
        bus.load       = inject && (cyc == 1);
        bus.start      = inject && (cyc == 1);
        bus.load_state = 32'hffffffff;
        tick();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        cyc++;
      end
    end
    check_eq("done_seen", 32'(got), 32'd1);
    if (got) begin
      check_eq("done_latency", 32'(cyc), 32'(3 * n));
      check_eq("busy_cycles", 32'(busy_cnt), 32'(3 * n));
      check_eq("busy_at_done", 32'(bus.busy), 32'd0);
      want = sb_q.pop_front();
      check_eq("rewind_result", bus.state_out, want);
      if (inject) begin
        bus.load       = 1'b1;
        bus.start      = 1'b1;
        bus.load_state = 32'h0badf00d;
      end
      tick();
      bus.load  = 1'b0;
      bus.start = 1'b0;
      check_eq("done_single", 32'(bus.done), 32'd0);
      check_eq("idle_busy", 32'(bus.busy), 32'd0);
      check_eq("result_held", bus.state_out, want);
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    logic [31:0] v;
    bus.load       = 1'b0;
    bus.load_state = '0;
    bus.start      = 1'b0;
    bus.steps      = '0;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("reset_state", bus.state_out, 32'hdeadbeef);
    check_eq("reset_busy", 32'(bus.busy), 32'd0);
    check_eq("reset_done", 32'(bus.done), 32'd0);

    do_load(32'h00042021);
    run_rewind(1, 32'h00000001, 1'b0);

    do_load(32'd2647435461);
    run_rewind(3, 32'h00000001, 1'b0);

    do_load(32'd67634689);
    run_rewind(1, 32'd270369, 1'b0);

    do_load(fwd(fwd(32'h12345678)));
    run_rewind(2, 32'h12345678, 1'b1);

    // load wins over a simultaneous start
    bus.load       = 1'b1;
    bus.start      = 1'b1;
    bus.load_state = 32'hcafef00d;
    bus.steps      = 16'd3;
    tick();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    check_eq("ls_state", bus.state_out, 32'hcafef00d);
    for (int i = 0; i < 3; i++) begin
      check_eq("ls_busy", 32'(bus.busy), 32'd0);
      check_eq("ls_done", 32'(bus.done), 32'd0);
      tick();
    end

    run_rewind(0, 32'hcafef00d, 1'b0);

    do_load(32'h0);
    run_rewind(5, 32'h0, 1'b0);

    v = 32'hdeadbeef;
    for (int i = 0; i < 1000; i++) v = fwd(v);
    do_load(v);
    run_rewind(1000, 32'hdeadbeef, 1'b0);

    // reset in the middle of a long rewind
    do_load(32'h00042021);
    bus.start = 1'b1;
    bus.steps = 16'd1000;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    check_eq("mid_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    tick();
    check_eq("rst_mid_state", bus.state_out, 32'hdeadbeef);
    check_eq("rst_mid_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_mid_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    check_eq("post_rst_state", bus.state_out, 32'hdeadbeef);
    check_eq("post_rst_busy", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xorshift_rewind.md
# xorshift_rewind

Multi-cycle inverse of the 32-bit xorshift generator (shift triple 13/17/5) used for the synth's noise and randomisation sources. Given a generator state, it steps the sequence backwards a requested number of times, undoing one shift-xor stage per clock. Voice and effect logic use it to replay a noise pattern from a saved point, or to recover a seed from a captured value. It is also the bench's round-trip checker for the forward generator.

## Interface
- `SEED`, default 32'hdeadbeef: state-register value after reset.
- `COUNT_W`, default 16: width of the step-count input.

- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `load` in 1: in IDLE, replace the state register with `load_state`.
- `load_state` in 32: state value to load.
- `start` in 1: in IDLE, begin rewinding by `steps`.
- `steps` in COUNT_W: number of backward steps, sampled with `start`.
- `state_out` out 32: state register; valid whenever `busy`=0.
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse when an operation completes.

## Operation
- Forward step: a = s^(s<<13); b = a^(a>>17); c = b^(b<<5). All arithmetic is 32-bit; shifted-out bits are discarded.
- One backward step runs three stages, one per clock, in this order:
  - UNDO5: x = y^(y<<5)^(y<<10)^(y<<15)^(y<<20)^(y<<25)^(y<<30).
  - UNDO17: x = y^(y>>17).
  - UNDO13: x = y^(y<<13)^(y<<26).
- Each stage writes its result back into the state register.
- FSM states: IDLE, UNDO5, UNDO17, UNDO13, DONE.
  - IDLE, `load`=1: state <= `load_state`. Remain in IDLE.
  - IDLE, `start`=1, `load`=0, `steps`≠0: remaining <= `steps`; go to UNDO5.
  - IDLE, `start`=1, `load`=0, `steps`=0: go to DONE. State is unchanged.
  - UNDO5 -> UNDO17 -> UNDO13.
  - UNDO13: if remaining==1, go to DONE; else remaining <= remaining-1 and go to UNDO5.
  - DONE -> IDLE unconditionally.
- Outputs by state:
  - `busy`=1 in UNDO5, UNDO17 and UNDO13; 0 elsewhere.
  - `done`=1 only in DONE.
- Reset values: state=`SEED`, FSM=IDLE, remaining=0, `busy`=0, `done`=0.
- Boundary conditions:
  - `load` and `start` asserted in the same IDLE cycle: `load` wins and `start` is ignored.
  - `load` and `start` are ignored outside IDLE, including in DONE.
  - A state of 0 is a fixed point. Rewinding it yields 0; this is legal and not flagged.
  - `steps` of all-ones runs to completion; there is no early abort.
  - `reset` mid-operation immediately forces the reset values. The partial result is discarded.
  - `state_out` shows intermediate stage values while `busy`=1. Consumers must not sample it then.

## Timing
- `start` is sampled at edge E0.
- For N≥1:
  - `busy` is high from E0 to E0+3N.
  - The final state is registered at E0+3N.
  - `done` is high for the single cycle between E0+3N and E0+3N+1.
  - IDLE is re-entered at E0+3N+1. A new `start` is accepted at that edge or later.
- For N=0, `done` is high between E0 and E0+1.
- `load` takes effect at the sampling edge; `state_out` shows the new value the following cycle.
- No combinational path runs from inputs to outputs. All outputs are registered or decoded from the FSM.

## Structure
- Shared package `xorshift_pkg`:
  - `XS_WIDTH`=32.
  - Shift constants `XS_A`=13, `XS_B`=17, `XS_C`=5.
  - FSM state typedef.
  - These are also used by the forward generator.
- Sub-module `xorshift_inv_stage`:
  - Combinational; parameterised by shift amount K and direction (left/right).
  - Computes the inverse of y^(y shift K) by xoring y shifted by every multiple of K below 32.
  - Instantiate three times (5 left, 17 right, 13 left). A mux on the FSM state selects which result is written.
- Top level holds the FSM, the COUNT_W-bit remaining counter and the state register.

## Test plan
- Reset with default `SEED` -> `state_out`=32'hdeadbeef, `busy`=0, `done`=0. Assert `reset` mid-rewind -> same values on the next cycle.
- Load 32'h00042021, start with `steps`=1:
  - `busy` is high for 3 cycles.
  - `done` pulses once.
  - `state_out`=32'h00000001.
- Load 32'd2647435461, start with `steps`=3 -> `done` exactly 9 cycles after the start edge, `state_out`=1. Load 32'd67634689, `steps`=1 -> `state_out`=32'd270369.
- Round trip:
  - Run a forward generator from 32'hdeadbeef for 1000 steps.
  - Load its value and rewind with `steps`=1000.
  - Expect `state_out`=32'hdeadbeef, with `done` 3000 cycles after start.
- Same-cycle `load`+`start` -> load only and no `busy`. `start` with `steps`=0 -> one `done` pulse the next cycle and state unchanged. `load` during `busy` -> ignored.
- Load 0, `steps`=5 -> `state_out`=0 after 15 cycles, single `done` pulse.
